// File: rtl/mprj_bram_wb.sv
// Caravel user-project Wishbone slave wrapping a byte-writable BRAM.
// Every access completes after a fixed DELAY-cycle latency.
//
// state  | meaning
// S_IDLE | waiting for a hit; bus inputs are sampled only here
// S_WAIT | latency down-count; dropping cyc/stb aborts the access
// S_ACK  | one-cycle ack; write lands on the closing edge, read data is presented
`timescale 1ns/1ps

module mprj_bram_wb #(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] BASE_SEL   = 8'h38,
  parameter int         DELAY      = 10
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [7:0] CNT_LOAD  = 8'(DELAY - 1);
  localparam bit         ONE_CYCLE = (DELAY == 1);

  state_t                state;
  logic [7:0]            cnt;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           dat_q;
  logic                  rd_valid;
  logic [31:0]           ram_q;
  logic [31:0]           ram [0:(1 << ADDR_WIDTH) - 1];

  logic bus_live;
  logic hit;
  logic rd_en;
  logic wr_en;
  logic unused_adr_bits;

  assign bus_live = wbs_cyc_i & wbs_stb_i;
  assign hit      = bus_live & (wbs_adr_i[31:24] == BASE_SEL);

  // Single RAM port: the bus address is used only for the IDLE->ACK read of a one-cycle build.
  assign ram_addr = (state == S_IDLE) ? wbs_adr_i[ADDR_WIDTH+1:2] : adr_q;
  assign wr_en    = (state == S_ACK) & we_q;
  assign rd_en    = ONE_CYCLE ? ((state == S_IDLE) & hit & ~wbs_we_i)
                              : ((state == S_WAIT) & bus_live & (cnt == 8'd1) & ~we_q);

  assign unused_adr_bits = ^{wbs_adr_i[23:ADDR_WIDTH+2], wbs_adr_i[1:0]};

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && sel_q[b]) ram[ram_addr][8*b +: 8] <= dat_q[8*b +: 8];
    end
    if (rd_en) ram_q <= ram[ram_addr];
  end

  // The RAM output register has no reset, so a valid flag forces the bus data to 0 after reset.
  assign wbs_dat_o = rd_valid ? ram_q : 32'h0;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      dat_q     <= 32'h0;
      rd_valid  <= 1'b0;
      wbs_ack_o <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      if (rd_en) rd_valid <= 1'b1;
      case (state)
        S_IDLE: begin
          if (hit) begin
            adr_q <= wbs_adr_i[ADDR_WIDTH+1:2];
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            dat_q <= wbs_dat_i;
            cnt   <= CNT_LOAD;
            if (ONE_CYCLE) begin
              state     <= S_ACK;
              wbs_ack_o <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus_live) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              state     <= S_ACK;
              wbs_ack_o <= 1'b1;
            end
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_bram_wb.sv
// Directed bench for mprj_bram_wb: a DELAY=10 instance and a DELAY=1 instance on one clock.
`timescale 1ns/1ps

module tb_mprj_bram_wb;

  logic        clock = 1'b0;
  logic        resetb;
  logic        cyc0, stb0, we0, ack0;
  logic [3:0]  sel0;
  logic [31:0] adr0, wdat0, dat0;
  logic        cyc1, stb1, we1, ack1;
  logic [3:0]  sel1;
  logic [31:0] adr1, wdat1, dat1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mprj_bram_wb #(.ADDR_WIDTH(10), .BASE_SEL(8'h38), .DELAY(10)) u_dut (
    .clock(clock), .resetb(resetb),
    .wbs_cyc_i(cyc0), .wbs_stb_i(stb0), .wbs_we_i(we0), .wbs_sel_i(sel0),
    .wbs_adr_i(adr0), .wbs_dat_i(wdat0), .wbs_ack_o(ack0), .wbs_dat_o(dat0)
  );

  mprj_bram_wb #(.ADDR_WIDTH(10), .BASE_SEL(8'h38), .DELAY(1)) u_dut1 (
    .clock(clock), .resetb(resetb),
    .wbs_cyc_i(cyc1), .wbs_stb_i(stb1), .wbs_we_i(we1), .wbs_sel_i(sel1),
    .wbs_adr_i(adr1), .wbs_dat_i(wdat1), .wbs_ack_o(ack1), .wbs_dat_o(dat1)
  );

  task automatic drive(input int d, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [3:0] sl, input logic [31:0] wd);
    if (d == 0) begin
      cyc0 = c; stb0 = s; we0 = w; adr0 = a; sel0 = sl; wdat0 = wd;
    end else begin
      cyc1 = c; stb1 = s; we1 = w; adr1 = a; sel1 = sl; wdat1 = wd;
    end
  endtask

  // lat = number of edges from the sampling edge (1) to the edge after which ack is seen; -1 on timeout
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] sl,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat);
    int n = 0;
    lat = -1;
    rd  = 32'h0;
    @(negedge clock);
    drive(d, 1'b1, 1'b1, w, a, sl, wd);
    while (n < 40 && lat < 0) begin
      @(posedge clock); #1; n++;
      if ((d == 0 ? ack0 : ack1) === 1'b1) begin
        lat = n;
        rd  = (d == 0) ? dat0 : dat1;
      end
    end
    drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clock);
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b want 0", ack0); end
    checks++; if (dat0 !== 32'h0) begin errors++; $display("FAIL reset_dat0: got %h want 0", dat0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    checks++; if (dat1 !== 32'h0) begin errors++; $display("FAIL reset_dat1: got %h want 0", dat1); end
    @(negedge clock);
    resetb = 1'b1;
  endtask

  task automatic test_write_read;
    logic [31:0] rd, a, v;
    int lat;
    for (int i = 0; i < 4; i++) begin
      a = 32'h3800_0000 + 32'(4 * i);
      v = 32'h0000_003E + 32'(6 * i);
      xfer(0, 1'b1, a, 4'hF, v, rd, lat);
      checks++; if (lat !== 10) begin errors++; $display("FAIL wr_lat[%0d]: got %0d want 10", i, lat); end
      xfer(0, 1'b0, a, 4'hF, 32'h0, rd, lat);
      checks++; if (lat !== 10) begin errors++; $display("FAIL rd_lat[%0d]: got %0d want 10", i, lat); end
      checks++; if (rd !== v) begin errors++; $display("FAIL rd_data[%0d]: got %h want %h", i, rd, v); end
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd;
    int lat;
    xfer(0, 1'b1, 32'h3800_0010, 4'hF, 32'h1122_3344, rd, lat);
    xfer(0, 1'b1, 32'h3800_0010, 4'b0010, 32'hAABB_CCDD, rd, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL lane_wr_lat: got %0d want 10", lat); end
    xfer(0, 1'b0, 32'h3800_0010, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h1122_CC44) begin errors++; $display("FAIL lane_data: got %h want 1122cc44", rd); end
    xfer(0, 1'b1, 32'h3800_0010, 4'b0000, 32'hFFFF_FFFF, rd, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL sel0_ack_lat: got %0d want 10", lat); end
    xfer(0, 1'b0, 32'h3800_0010, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h1122_CC44) begin errors++; $display("FAIL sel0_data: got %h want 1122cc44", rd); end
  endtask

  task automatic test_miss;
    logic [31:0] rd;
    int lat;
    int acks = 0;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h3000_0000, 4'hF, 32'h0);
    repeat (100) begin @(posedge clock); #1; if (ack0 === 1'b1) acks++; end
    drive(0, 1'b1, 1'b1, 1'b1, 32'h3000_0010, 4'hF, 32'h0);
    repeat (20) begin @(posedge clock); #1; if (ack0 === 1'b1) acks++; end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (acks !== 0) begin errors++; $display("FAIL miss_ack: got %0d acks want 0", acks); end
    checks++; if (dat0 !== 32'h1122_CC44) begin errors++; $display("FAIL miss_dat: got %h want 1122cc44", dat0); end
    xfer(0, 1'b0, 32'h3800_0010, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h1122_CC44) begin errors++; $display("FAIL miss_nowrite: got %h want 1122cc44", rd); end
  endtask

  task automatic test_alias;
    logic [31:0] rd;
    int lat;
    xfer(0, 1'b1, 32'h3800_1000, 4'hF, 32'hDEAD_BEEF, rd, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL alias_wr_lat: got %0d want 10", lat); end
    xfer(0, 1'b0, 32'h3800_0000, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alias_rd0: got %h want deadbeef", rd); end
    xfer(0, 1'b0, 32'h38FF_F000, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alias_rd_top: got %h want deadbeef", rd); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL alias_rd_lat: got %0d want 10", lat); end
  endtask

  task automatic test_abort;
    logic [31:0] rd;
    int lat;
    int acks = 0;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h3800_0004, 4'hF, 32'h1234_5678);
    repeat (6) begin @(posedge clock); #1; if (ack0 === 1'b1) acks++; end
    @(negedge clock);
    cyc0 = 1'b0;
    repeat (20) begin @(posedge clock); #1; if (ack0 === 1'b1) acks++; end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (acks !== 0) begin errors++; $display("FAIL abort_ack: got %0d acks want 0", acks); end
    checks++; if (dat0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL abort_dat: got %h want deadbeef", dat0); end
    xfer(0, 1'b0, 32'h3800_0004, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_0044) begin errors++; $display("FAIL abort_ram: got %h want 00000044", rd); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL abort_next_lat: got %0d want 10", lat); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int lat;
    xfer(0, 1'b0, 32'h3800_000C, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_0050) begin errors++; $display("FAIL rst_pre_rd: got %h want 00000050", rd); end
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h3800_0008, 4'hF, 32'h0);
    repeat (5) @(posedge clock);
    #2 resetb = 1'b0;
    #1;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b want 0", ack0); end
    checks++; if (dat0 !== 32'h0) begin errors++; $display("FAIL rst_mid_dat: got %h want 0", dat0); end
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    resetb = 1'b1;
    // reset on the last WAIT cycle of a write must suppress the write
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h3800_000C, 4'hF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clock);
    #2 resetb = 1'b0;
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    resetb = 1'b1;
    xfer(0, 1'b0, 32'h3800_0008, 4'hF, 32'h0, rd, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL rst_post_lat: got %0d want 10", lat); end
    checks++; if (rd !== 32'h0000_004A) begin errors++; $display("FAIL rst_post_rd: got %h want 0000004a", rd); end
    xfer(0, 1'b0, 32'h3800_000C, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_0050) begin errors++; $display("FAIL rst_nowrite: got %h want 00000050", rd); end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int first = -1;
    int second = -1;
    int acks = 0;
    logic [31:0] d1 = 32'h0;
    logic [31:0] d2 = 32'h0;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h3800_0000, 4'hF, 32'h0);
    while (n < 40 && second < 0) begin
      @(posedge clock); #1; n++;
      if (ack0 === 1'b1) begin
        acks++;
        if (first < 0) begin
          first = n; d1 = dat0;
          adr0 = 32'h3800_0008;
        end else begin
          second = n; d2 = dat0;
        end
      end
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clock);
    checks++; if (first !== 10) begin errors++; $display("FAIL b2b_first: got %0d want 10", first); end
    checks++; if (d1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_d1: got %h want deadbeef", d1); end
    checks++; if (second !== 21) begin errors++; $display("FAIL b2b_second: got %0d want 21", second); end
    checks++; if (d2 !== 32'h0000_004A) begin errors++; $display("FAIL b2b_d2: got %h want 0000004a", d2); end
    checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_acks: got %0d want 2", acks); end
  endtask

  task automatic test_delay1;
    logic [31:0] rd, a, v;
    int lat;
    xfer(1, 1'b1, 32'h3800_0000, 4'hF, 32'hA5A5_0001, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL d1_wr0_lat: got %0d want 1", lat); end
    xfer(1, 1'b1, 32'h3800_0004, 4'hF, 32'h5A5A_0002, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL d1_wr1_lat: got %0d want 1", lat); end
    for (int i = 0; i < 3; i++) begin
      a = (i == 1) ? 32'h3800_0004 : 32'h3800_0000;
      v = (i == 1) ? 32'h5A5A_0002 : 32'hA5A5_0001;
      xfer(1, 1'b0, a, 4'hF, 32'h0, rd, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL d1_rd_lat[%0d]: got %0d want 1", i, lat); end
      checks++; if (rd !== v) begin errors++; $display("FAIL d1_rd_data[%0d]: got %h want %h", i, rd, v); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_miss();
    test_alias();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_delay1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
